// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the rPLL sequencing controller.
//   pll_state_e  : controller state encoding
//   ODSEL_DIV*   : Gowin ODSEL codes for the supported output dividers
//   DEF_*        : power-up divider settings (27 MHz in, /4 output path)
//   gowin_dsel() : maps a plain-binary divider select onto the inverted
//                  encoding the rPLL dynamic IDSEL/FBDSEL pins expect
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_ERROR  = 3'd4
  } pll_state_e;

  localparam logic [5:0] ODSEL_DIV2  = 6'b111111;
  localparam logic [5:0] ODSEL_DIV4  = 6'b111110;
  localparam logic [5:0] ODSEL_DIV8  = 6'b111100;
  localparam logic [5:0] ODSEL_DIV16 = 6'b111000;
  localparam logic [5:0] ODSEL_DIV32 = 6'b110000;

  localparam logic [5:0] DEF_IDIV  = 6'd2;
  localparam logic [5:0] DEF_FBDIV = 6'd13;
  localparam logic [5:0] DEF_ODSEL = ODSEL_DIV4;

  localparam int TMR_W = 17;
  localparam int STB_W = 11;

  function automatic logic [5:0] gowin_dsel(input logic [5:0] sel);
    return ~sel;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow, level-type asynchronous bits (PLL lock,
// status flags). Latency is two clk edges.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, flops clear to RST_VAL
//   d     : asynchronous input
//   q     : synchronized output
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// Sequencing controller for the Gowin rPLL: resets the PLL, loads the dynamic
// divider selects, qualifies LOCK, retries on lock timeout and releases a
// lock-gated downstream reset. Runs on the 27 MHz reference, never on a PLL
// output, so it keeps working while the PLL is unlocked.
//   clkin       : reference clock
//   rst_n       : asynchronous active-low reset
//   cfg_req     : level request for a new divider set, held until cfg_ack
//   cfg_idiv    : IDIV_SEL, plain binary
//   cfg_fbdiv   : FBDIV_SEL, plain binary
//   cfg_odsel   : ODSEL code, already encoded
//   cfg_ack     : one-cycle accept pulse
//   pll_lock    : raw PLL LOCK (asynchronous)
//   pll_reset   : PLL RESET, active high
//   pll_idsel   : PLL IDSEL (inverted encoding)
//   pll_fbdsel  : PLL FBDSEL (inverted encoding)
//   pll_odsel   : PLL ODSEL
//   sys_rst_n   : downstream reset, only released while locked
//   locked      : stable-lock status
//   busy        : sequencing in progress (not RUN, not ERROR)
//   error       : retries exhausted
//   retry_cnt   : failed attempts in the current sequence
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_HOLD   | pll_reset asserted for RST_CYCLES
// ST_WAIT   | reset released, waiting for synchronized lock or timeout
// ST_STABLE | lock seen, must stay high for LOCK_STABLE cycles
// ST_RUN    | locked, downstream reset released, accepting cfg_req
// ST_ERROR  | MAX_RETRY attempts failed, PLL held in reset until cfg_req
module pll_reconfig_ctrl #(
  parameter int         RST_CYCLES   = 16,
  parameter int         LOCK_STABLE  = 1024,
  parameter int         LOCK_TIMEOUT = 65536,
  parameter int         MAX_RETRY    = 3,
  parameter logic [5:0] DEF_IDIV     = pll_ctrl_pkg::DEF_IDIV,
  parameter logic [5:0] DEF_FBDIV    = pll_ctrl_pkg::DEF_FBDIV,
  parameter logic [5:0] DEF_ODSEL    = pll_ctrl_pkg::DEF_ODSEL
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       cfg_req,
  input  logic [5:0] cfg_idiv,
  input  logic [5:0] cfg_fbdiv,
  input  logic [5:0] cfg_odsel,
  output logic       cfg_ack,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel,
  output logic       sys_rst_n,
  output logic       locked,
  output logic       busy,
  output logic       error,
  output logic [1:0] retry_cnt
);

  import pll_ctrl_pkg::*;

  // Both timers count down from a load value to zero; "cleared" in the state
  // description corresponds to reloading here.
  localparam logic [TMR_W-1:0] HOLD_LOAD    = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ONE      = TMR_W'(1);
  localparam logic [STB_W-1:0] STABLE_LOAD  = STB_W'(LOCK_STABLE - 1);
  localparam logic [STB_W-1:0] STB_ONE      = STB_W'(1);
  localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRY);

  pll_state_e       state;
  logic [TMR_W-1:0] tmr;
  logic [STB_W-1:0] stb_tmr;
  logic             lock_s;
  logic [1:0]       retry_inc;

  sync_2ff #(.WIDTH(1), .RST_VAL(1'b0)) u_lock_sync (
    .clk   (clkin),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign retry_inc = retry_cnt + 2'd1;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_HOLD;
      tmr        <= HOLD_LOAD;
      stb_tmr    <= STABLE_LOAD;
      pll_reset  <= 1'b1;
      sys_rst_n  <= 1'b0;
      locked     <= 1'b0;
      busy       <= 1'b1;
      error      <= 1'b0;
      cfg_ack    <= 1'b0;
      retry_cnt  <= 2'd0;
      pll_idsel  <= gowin_dsel(DEF_IDIV);
      pll_fbdsel <= gowin_dsel(DEF_FBDIV);
      pll_odsel  <= DEF_ODSEL;
    end else begin
      cfg_ack <= 1'b0;
      case (state)
        ST_HOLD: begin
          if (tmr == '0) begin
            state     <= ST_WAIT;
            tmr       <= TIMEOUT_LOAD;
            pll_reset <= 1'b0;
          end else begin
            tmr <= tmr - TMR_ONE;
          end
        end

        ST_WAIT: begin
          if (lock_s) begin
            state   <= ST_STABLE;
            stb_tmr <= STABLE_LOAD;
          end else if (tmr == '0) begin
            retry_cnt <= retry_inc;
            tmr       <= HOLD_LOAD;
            pll_reset <= 1'b1;
            if (retry_inc == RETRY_LIMIT) begin
              state <= ST_ERROR;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              state <= ST_HOLD;
            end
          end else begin
            tmr <= tmr - TMR_ONE;
          end
        end

        ST_STABLE: begin
          // The timeout keeps running (saturating) so a lock that keeps
          // glitching back to WAIT still ends in a retry.
          if (tmr != '0) begin
            tmr <= tmr - TMR_ONE;
          end
          if (!lock_s) begin
            state <= ST_WAIT;
          end else if (stb_tmr == '0) begin
            state     <= ST_RUN;
            retry_cnt <= 2'd0;
            locked    <= 1'b1;
            sys_rst_n <= 1'b1;
            busy      <= 1'b0;
          end else begin
            stb_tmr <= stb_tmr - STB_ONE;
          end
        end

        ST_RUN: begin
          // Lock loss takes priority; a coincident request is left pending
          // and picked up on the next RUN cycle.
          if (!lock_s || cfg_req) begin
            state     <= ST_HOLD;
            tmr       <= HOLD_LOAD;
            pll_reset <= 1'b1;
            sys_rst_n <= 1'b0;
            locked    <= 1'b0;
            busy      <= 1'b1;
            retry_cnt <= 2'd0;
            if (lock_s) begin
              cfg_ack    <= 1'b1;
              pll_idsel  <= gowin_dsel(cfg_idiv);
              pll_fbdsel <= gowin_dsel(cfg_fbdiv);
              pll_odsel  <= cfg_odsel;
            end
          end
        end

        ST_ERROR: begin
          if (cfg_req) begin
            state      <= ST_HOLD;
            tmr        <= HOLD_LOAD;
            busy       <= 1'b1;
            error      <= 1'b0;
            retry_cnt  <= 2'd0;
            cfg_ack    <= 1'b1;
            pll_idsel  <= gowin_dsel(cfg_idiv);
            pll_fbdsel <= gowin_dsel(cfg_fbdiv);
            pll_odsel  <= cfg_odsel;
          end
        end

        default: begin
          state     <= ST_HOLD;
          tmr       <= HOLD_LOAD;
          pll_reset <= 1'b1;
          sys_rst_n <= 1'b0;
          locked    <= 1'b0;
          busy      <= 1'b1;
          error     <= 1'b0;
        end
      endcase
    end
  end

endmodule
